// File: rtl/data_sram_responder.sv
// Responder end of the data-SRAM interface: a word-organised, byte-writable memory.
// Read data returns after a fixed latency; out-of-window accesses are flagged and counted.
module data_sram_responder #(
    parameter int          ADDR_WIDTH = 12,
    parameter logic [31:0] BASE_ADDR  = 32'h1c80_0000,
    parameter int          RD_LATENCY = 1,
    parameter int          CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 data_sram_en,
    input  logic [3:0]           data_sram_we,
    input  logic [31:0]          data_sram_addr,
    input  logic [31:0]          data_sram_wdata,
    output logic [31:0]          data_sram_rdata,
    output logic                 rdata_valid,
    output logic                 addr_err,
    output logic [CNT_WIDTH-1:0] rd_cnt,
    output logic [CNT_WIDTH-1:0] wr_cnt
);

    localparam int DEPTH   = 1 << ADDR_WIDTH;
    localparam int TAG_LSB = ADDR_WIDTH + 2;
    localparam int LAST    = RD_LATENCY - 1;

    logic [31:0]           mem [DEPTH];
    logic                  in_window;
    logic [ADDR_WIDTH-1:0] index;
    logic                  rd_req;
    logic                  wr_req;
    logic [31:0]           rd_word;
    logic                  addr_lsb_unused;

    assign in_window       = (data_sram_addr[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]);
    assign index           = data_sram_addr[TAG_LSB-1:2];
    assign rd_req          = data_sram_en && (data_sram_we == 4'b0000);
    assign wr_req          = data_sram_en && (data_sram_we != 4'b0000);
    assign rd_word         = in_window ? mem[index] : 32'h0;
    assign addr_lsb_unused = ^data_sram_addr[1:0];

    // Storage is deliberately left out of reset so contents survive a resetn pulse.
    always_ff @(posedge clk) begin
        if (wr_req && in_window) begin
            for (int i = 0; i < 4; i++) begin
                if (data_sram_we[i]) begin
                    mem[index][8*i +: 8] <= data_sram_wdata[8*i +: 8];
                end
            end
        end
    end

    logic [RD_LATENCY-1:0] pipe_valid;
    logic [RD_LATENCY-1:0] pipe_err;
    logic [31:0]           pipe_data [RD_LATENCY];

    // Writes ride the pipeline as non-valid entries so their window error lines up with reads.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pipe_valid <= '0;
            pipe_err   <= '0;
            for (int s = 0; s < RD_LATENCY; s++) begin
                pipe_data[s] <= 32'h0;
            end
        end else begin
            pipe_valid[0] <= rd_req;
            pipe_err[0]   <= data_sram_en && !in_window;
            pipe_data[0]  <= rd_word;
            for (int s = 1; s < RD_LATENCY; s++) begin
                pipe_valid[s] <= pipe_valid[s-1];
                pipe_err[s]   <= pipe_err[s-1];
                pipe_data[s]  <= pipe_data[s-1];
            end
        end
    end

    logic [31:0] rdata_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdata_q <= 32'h0;
        end else if (pipe_valid[LAST]) begin
            rdata_q <= pipe_data[LAST];
        end
    end

    assign rdata_valid     = pipe_valid[LAST];
    assign addr_err        = pipe_err[LAST];
    assign data_sram_rdata = pipe_valid[LAST] ? pipe_data[LAST] : rdata_q;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_cnt <= '0;
            wr_cnt <= '0;
        end else begin
            if (rd_req && (rd_cnt != '1)) begin
                rd_cnt <= rd_cnt + CNT_ONE;
            end
            if (wr_req && (wr_cnt != '1)) begin
                wr_cnt <= wr_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: two instances (latency 1 with 4-bit counters, latency 3
// with 16-bit counters) share one stimulus stream and are checked against a response-queue model.
module tb_data_sram_responder;

    localparam logic [31:0] BASE = 32'h1c80_0000;

    logic        clk = 1'b0;
    logic        resetn;
    logic        en;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;

    logic [31:0] rdata1, rdata3;
    logic        valid1, valid3, err1, err3;
    logic [3:0]  rdc1, wrc1;
    logic [15:0] rdc3, wrc3;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 1'b0;

    always #5 clk = ~clk;

    data_sram_responder #(.RD_LATENCY(1), .CNT_WIDTH(4)) u_lat1 (
        .clk(clk), .resetn(resetn), .data_sram_en(en), .data_sram_we(we),
        .data_sram_addr(addr), .data_sram_wdata(wdata), .data_sram_rdata(rdata1),
        .rdata_valid(valid1), .addr_err(err1), .rd_cnt(rdc1), .wr_cnt(wrc1)
    );

    data_sram_responder #(.RD_LATENCY(3), .CNT_WIDTH(16)) u_lat3 (
        .clk(clk), .resetn(resetn), .data_sram_en(en), .data_sram_we(we),
        .data_sram_addr(addr), .data_sram_wdata(wdata), .data_sram_rdata(rdata3),
        .rdata_valid(valid3), .addr_err(err3), .rd_cnt(rdc3), .wr_cnt(wrc3)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int          d;
        int          due;
        bit          valid;
        bit          err;
        logic [31:0] data;
    } resp_t;

    resp_t       pend[$];
    logic [31:0] m_mem [16];
    int          cyc = 0;
    bit          e_valid [2] = '{0, 0};
    bit          e_err   [2] = '{0, 0};
    logic [31:0] e_data  [2] = '{32'h0, 32'h0};
    int          e_rd    [2] = '{0, 0};
    int          e_wr    [2] = '{0, 0};
    logic        m_inw;
    int          m_idx;
    logic [31:0] m_word;

    function automatic int lat(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic int cmax(input int d);
        return (d == 0) ? 15 : 65535;
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pend.delete();
            for (int d = 0; d < 2; d++) begin
                e_valid[d] = 0; e_err[d] = 0; e_data[d] = 32'h0; e_rd[d] = 0; e_wr[d] = 0;
            end
        end else begin
            cyc++;
            m_inw = (addr[31:14] == BASE[31:14]);
            m_idx = int'(addr[13:2]);
            m_word = 32'h0;
            if (m_inw && m_idx < 16) m_word = m_mem[m_idx];
            if (en) begin
                for (int d = 0; d < 2; d++) begin
                    if (we == 4'h0) begin
                        pend.push_back('{d, cyc + lat(d) - 1, 1'b1, !m_inw, m_word});
                        if (e_rd[d] < cmax(d)) e_rd[d]++;
                    end else begin
                        if (!m_inw) pend.push_back('{d, cyc + lat(d) - 1, 1'b0, 1'b1, 32'h0});
                        if (e_wr[d] < cmax(d)) e_wr[d]++;
                    end
                end
                if (we != 4'h0 && m_inw && m_idx < 16) begin
                    for (int b = 0; b < 4; b++)
                        if (we[b]) m_mem[m_idx][8*b +: 8] = wdata[8*b +: 8];
                end
            end
            for (int d = 0; d < 2; d++) begin
                e_valid[d] = 0;
                e_err[d]   = 0;
            end
            for (int i = pend.size() - 1; i >= 0; i--) begin
                if (pend[i].due == cyc) begin
                    e_valid[pend[i].d] = pend[i].valid;
                    e_err[pend[i].d]   = pend[i].err;
                    if (pend[i].valid) e_data[pend[i].d] = pend[i].data;
                    pend.delete(i);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("m_valid1", 32'(valid1), 32'(e_valid[0]));
            chk("m_err1",   32'(err1),   32'(e_err[0]));
            chk("m_data1",  rdata1,      e_data[0]);
            chk("m_rdcnt1", 32'(rdc1),   32'(e_rd[0]));
            chk("m_wrcnt1", 32'(wrc1),   32'(e_wr[0]));
            chk("m_valid3", 32'(valid3), 32'(e_valid[1]));
            chk("m_err3",   32'(err3),   32'(e_err[1]));
            chk("m_data3",  rdata3,      e_data[1]);
            chk("m_rdcnt3", 32'(rdc3),   32'(e_rd[1]));
            chk("m_wrcnt3", 32'(wrc3),   32'(e_wr[1]));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input bit e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
        en = e; we = w; addr = a; wdata = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        idle(2);
        resetn = 1'b1;
    endtask

    logic [31:0] ra;

    initial begin
        resetn = 1'b0; en = 1'b0; we = 4'h0; addr = 32'h0; wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk_on = 1'b1;
        chk("rst_rdata1", rdata1, 32'h0);
        chk("rst_valid1", 32'(valid1), 32'h0);
        chk("rst_err3",   32'(err3), 32'h0);
        chk("rst_rdcnt3", 32'(rdc3), 32'h0);
        resetn = 1'b1;

        for (int i = 0; i < 16; i++) step(1'b1, 4'hF, BASE + 32'(i * 4), 32'hF00D_0000 | 32'(i));
        idle(3);
        do_reset();
        chk("rst_wrcnt1", 32'(wrc1), 32'h0);

        // read index 0, latency 1
        chk("pre_valid1", 32'(valid1), 32'h0);
        step(1'b1, 4'h0, BASE, 32'h0);
        chk("rd0_valid1", 32'(valid1), 32'h1);
        chk("rd0_data1",  rdata1, 32'hF00D_0000);
        chk("rd0_rdcnt1", 32'(rdc1), 32'h1);
        idle(1);
        chk("rd0_after_valid1", 32'(valid1), 32'h0);
        idle(3);

        // byte-lane merge
        do_reset();
        step(1'b1, 4'hF,    BASE + 32'h10, 32'hAABB_CCDD);
        step(1'b1, 4'b0101, BASE + 32'h10, 32'h1122_3344);
        step(1'b1, 4'h0,    BASE + 32'h10, 32'h0);
        chk("merge_data1",  rdata1, 32'hAA22_CC44);
        chk("merge_wrcnt1", 32'(wrc1), 32'h2);
        chk("merge_rdcnt1", 32'(rdc1), 32'h1);

        // out-of-window read and write
        step(1'b1, 4'h0, 32'h0000_0010, 32'h0);
        chk("oow_rd_valid1", 32'(valid1), 32'h1);
        chk("oow_rd_err1",   32'(err1), 32'h1);
        chk("oow_rd_data1",  rdata1, 32'h0);
        step(1'b1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF);
        chk("oow_wr_err1",   32'(err1), 32'h1);
        chk("oow_wr_valid1", 32'(valid1), 32'h0);
        step(1'b1, 4'h0, BASE + 32'h10, 32'h0);
        chk("oow_readback1", rdata1, 32'hAA22_CC44);
        chk("oow_readback_err1", 32'(err1), 32'h0);
        idle(4);

        // latency 3: four back-to-back reads of idx 8..11
        for (int i = 0; i < 8; i++) begin
            if (i < 4) step(1'b1, 4'h0, BASE + 32'((8 + i) * 4), 32'h0);
            else       idle(1);
            chk("b2b_valid3", 32'(valid3), (i >= 2 && i <= 5) ? 32'h1 : 32'h0);
            if (i >= 2) chk("b2b_data3", rdata3, 32'hF00D_0008 + 32'((i - 2 > 3) ? 3 : i - 2));
        end

        // reset with two reads in flight on the latency-3 instance
        step(1'b1, 4'h0, BASE + 32'h20, 32'h0);
        step(1'b1, 4'h0, BASE + 32'h24, 32'h0);
        resetn = 1'b0;
        idle(2);
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            idle(1);
            chk("flush_valid3", 32'(valid3), 32'h0);
        end
        chk("flush_rdcnt3", 32'(rdc3), 32'h0);
        step(1'b1, 4'h0, BASE + 32'h20, 32'h0);
        idle(2);
        chk("post_rst_valid3", 32'(valid3), 32'h1);
        chk("post_rst_data3",  rdata3, 32'hF00D_0008);

        // counter saturation
        do_reset();
        for (int i = 0; i < 20; i++) step(1'b1, 4'h0, BASE + 32'((i % 16) * 4), 32'h0);
        chk("sat_rdcnt1", 32'(rdc1), 32'hF);
        chk("sat_wrcnt1", 32'(wrc1), 32'h0);
        chk("sat_rdcnt3", 32'(rdc3), 32'd20);
        idle(3);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic       e;
            logic [3:0] w;
            e = ($urandom_range(0, 99) < 80);
            w = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            if ($urandom_range(0, 9) < 8) begin
                ra = BASE + (32'($urandom_range(0, 15)) << 2) + 32'($urandom_range(0, 3));
            end else begin
                ra = $urandom;
                if (ra[31:14] == BASE[31:14]) ra[31] = ~ra[31];
            end
            step(e, w, ra, $urandom);
        end
        idle(5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
